// File: rtl/out_mon_pkg.sv
// Shared constants and state encoding for the output feedback monitor.
package out_mon_pkg;

    localparam int NP             = 8;
    localparam int NO             = 28;
    localparam int SETTLE_CYC_DEF = 500000;
    localparam int FILT_CYC_DEF   = 8;
    localparam int FILT_W         = 4;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

endpackage

// File: rtl/fb_chan_filter.sv
// One monitored channel: readback synchronizer, mismatch filter and fault latch.
// Macro FB_FORCE_OFF_EN: gate the channel's command off while its fault is latched.
module fb_chan_filter
    import out_mon_pkg::*;
#(
    parameter int FILT_CYC = FILT_CYC_DEF
) (
    input  logic pclk_50M,
    input  logic rst,
    input  logic fb_async,
    input  logic cmd,
    input  logic filt_en,
    input  logic clr,
    output logic mismatch,
    output logic hit,
    output logic fault,
    output logic gout
);

    localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILT_CYC);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYC - 1);

    logic              fb_sync_p0;
    logic              fb_sync_p1;
    logic [FILT_W-1:0] filt_cnt;

    // Stage p0/p1: two-flop synchronizer for the asynchronous readback
    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            fb_sync_p0 <= 1'b0;
            fb_sync_p1 <= 1'b0;
        end else begin
            fb_sync_p0 <= fb_async;
            fb_sync_p1 <= fb_sync_p0;
        end
    end

    assign mismatch = fb_sync_p1 ^ cmd;
    assign hit      = filt_en && mismatch && (filt_cnt >= FILT_LAST);

    always_ff @(posedge pclk_50M) begin
        if (rst || !filt_en || !mismatch) begin
            filt_cnt <= '0;
        end else if (filt_cnt != FILT_MAX) begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // A new latch event takes priority over a simultaneous clear
    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (hit) begin
            fault <= 1'b1;
        end else if (clr) begin
            fault <= 1'b0;
        end
    end

`ifdef FB_FORCE_OFF_EN
    assign gout = cmd & ~fault;
`else
    assign gout = cmd;
`endif

endmodule

// File: rtl/out_fb_monitor.sv
// Compares output-stage commands against relay/driver readback and latches
// per-channel faults after a settle mask and a consecutive-mismatch filter.
module out_fb_monitor
    import out_mon_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int FILT_CYC   = FILT_CYC_DEF
) (
    input  logic          pclk_50M,
    input  logic          rst,
    input  logic [1:NP]   eoutP,
    input  logic [1:NO]   eout,
    input  logic [1:NP]   fbP,
    input  logic [1:NO]   fb,
    input  logic          clr_fault,
    output logic [1:NP]   faultP,
    output logic [1:NO]   fault,
    output logic          any_fault,
    output logic          monitoring,
    output logic [1:NP]   goutP,
    output logic [1:NO]   gout
);

    localparam int              CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    mon_state_t       state;
    mon_state_t       state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] settle_cnt_nxt;
    logic             mask_act;
    logic             mask_act_nxt;

    logic [1:NP]      cmdP_p0;
    logic [1:NO]      cmd_p0;
    logic [1:NP]      mmP;
    logic [1:NO]      mm;
    logic [1:NP]      hitP;
    logic [1:NO]      hit;

    logic             cmd_chg;
    logic             any_mm;
    logic             any_hit;
    logic             filt_en;
    logic             clr_ok;

    // Stage p0: registered command, reference for change detection and compare
    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            cmdP_p0 <= '0;
            cmd_p0  <= '0;
        end else begin
            cmdP_p0 <= eoutP;
            cmd_p0  <= eout;
        end
    end

    assign cmd_chg   = (eoutP != cmdP_p0) || (eout != cmd_p0);
    assign any_mm    = (|mmP) | (|mm);
    assign any_hit   = (|hitP) | (|hit);
    assign any_fault = (|faultP) | (|fault);

    // In FAULT the settle mask is tracked separately so latched faults survive a command change
    assign filt_en = !cmd_chg &&
                     ((state == ST_MONITOR) || ((state == ST_FAULT) && !mask_act));
    assign clr_ok  = clr_fault && !any_mm && (state == ST_FAULT);

    for (genvar i = 1; i <= NP; i++) begin : g_pwr
        fb_chan_filter #(.FILT_CYC(FILT_CYC)) u_chan (
            .pclk_50M (pclk_50M),
            .rst      (rst),
            .fb_async (fbP[i]),
            .cmd      (cmdP_p0[i]),
            .filt_en  (filt_en),
            .clr      (clr_ok),
            .mismatch (mmP[i]),
            .hit      (hitP[i]),
            .fault    (faultP[i]),
            .gout     (goutP[i])
        );
    end

    for (genvar j = 1; j <= NO; j++) begin : g_sig
        fb_chan_filter #(.FILT_CYC(FILT_CYC)) u_chan (
            .pclk_50M (pclk_50M),
            .rst      (rst),
            .fb_async (fb[j]),
            .cmd      (cmd_p0[j]),
            .filt_en  (filt_en),
            .clr      (clr_ok),
            .mismatch (mm[j]),
            .hit      (hit[j]),
            .fault    (fault[j]),
            .gout     (gout[j])
        );
    end

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
            mask_act   <= 1'b0;
            monitoring <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            mask_act   <= mask_act_nxt;
            monitoring <= (state_nxt == ST_MONITOR);
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        mask_act_nxt   = mask_act;
        case (state)
            ST_SETTLE: begin
                if (cmd_chg) begin
                    settle_cnt_nxt = SETTLE_LOAD;
                end else if (settle_cnt == '0) begin
                    state_nxt = ST_MONITOR;
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end
            ST_MONITOR: begin
                if (cmd_chg) begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                end else if (any_hit) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clr_ok && !any_hit) begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                    mask_act_nxt   = 1'b0;
                end else if (cmd_chg) begin
                    settle_cnt_nxt = SETTLE_LOAD;
                    mask_act_nxt   = 1'b1;
                end else if (mask_act) begin
                    if (settle_cnt == '0) begin
                        mask_act_nxt = 1'b0;
                    end else begin
                        settle_cnt_nxt = settle_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt      = ST_SETTLE;
                settle_cnt_nxt = SETTLE_LOAD;
                mask_act_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_out_fb_monitor.sv
// Scoreboard bench for out_fb_monitor: a reference model queues expected outputs
// every clock and a separate monitor compares them against the DUT.
module tb_out_fb_monitor;

    localparam int SETTLE = 50;
    localparam int FILT   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:8]  eoutP, fbP, faultP, goutP;
    logic [1:28] eout, fb, fault, gout;
    logic        clr_fault, any_fault, monitoring;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        mon;
        logic        anyf;
        logic [35:0] flt;
        logic [35:0] g;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    out_fb_monitor #(.SETTLE_CYC(SETTLE), .FILT_CYC(FILT)) dut (
        .pclk_50M   (clk),
        .rst        (rst),
        .eoutP      (eoutP),
        .eout       (eout),
        .fbP        (fbP),
        .fb         (fb),
        .clr_fault  (clr_fault),
        .faultP     (faultP),
        .fault      (fault),
        .any_fault  (any_fault),
        .monitoring (monitoring),
        .goutP      (goutP),
        .gout       (gout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=settling, 1=monitoring, 2=faulted; since = cycles since last command change
    logic [35:0] m_cmd, m_s1, m_s2, m_flt;
    int          m_run[36];
    int          m_mode;
    int          m_since;

    initial begin
        logic [35:0] e, f, mis, hits;
        logic        chg, act, accept;
        exp_t        x;
        forever begin
            @(posedge clk);
            e = {eoutP, eout};
            f = {fbP, fb};
            if (rst) begin
                m_cmd = '0; m_s1 = '0; m_s2 = '0; m_flt = '0;
                m_mode = 0; m_since = 0;
                for (int i = 0; i < 36; i++) m_run[i] = 0;
            end else begin
                mis  = m_s2 ^ m_cmd;
                chg  = (e != m_cmd);
                act  = !chg && (m_mode == 1 || (m_mode == 2 && m_since >= SETTLE));
                hits = '0;
                for (int i = 0; i < 36; i++) begin
                    if (act && mis[i]) begin
                        m_run[i] = (m_run[i] + 1 > FILT) ? FILT : m_run[i] + 1;
                        if (m_run[i] == FILT) hits[i] = 1'b1;
                    end else begin
                        m_run[i] = 0;
                    end
                end
                accept = (m_mode == 2) && clr_fault && (mis == '0);
                m_flt  = accept ? hits : (m_flt | hits);
                if (accept) begin
                    m_mode = 0; m_since = 0;
                end else if (chg) begin
                    m_since = 0;
                    if (m_mode != 2) m_mode = 0;
                end else begin
                    if (m_since < SETTLE) m_since++;
                    if (m_mode == 0 && m_since >= SETTLE) m_mode = 1;
                    else if (m_mode == 1 && hits != '0) m_mode = 2;
                end
                m_s2 = m_s1; m_s1 = f; m_cmd = e;
            end
            x.mon  = (m_mode == 1);
            x.anyf = |m_flt;
            x.flt  = m_flt;
`ifdef FB_FORCE_OFF_EN
            x.g    = m_cmd & ~m_flt;
`else
            x.g    = m_cmd;
`endif
            exp_q.push_back(x);
        end
    end

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("monitoring", 64'(monitoring), 64'(x.mon));
                chk("any_fault", 64'(any_fault), 64'(x.anyf));
                chk("faults", 64'({faultP, fault}), 64'(x.flt));
                chk("gout", 64'({goutP, gout}), 64'(x.g));
            end
        end
    end

    task automatic count_until_mon(output int c);
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (monitoring) break;
        end
    endtask

    initial begin
        int          c;
        logic [1:28] exp_g;
        logic [35:0] v;
        int          r, idx;

        rst = 1'b1; clr_fault = 1'b0;
        eoutP = '0; fbP = '0; eout = '0; fb = '0;
        repeat (3) @(negedge clk);
        chk("reset_monitoring", 64'(monitoring), 64'd0);
        chk("reset_gout", 64'({goutP, gout}), 64'd0);

        // Power-up settle with matching feedback
        rst = 1'b0;
        count_until_mon(c);
        chk("settle_after_reset_cycles", 64'(c), 64'(SETTLE));
        chk("no_fault_after_settle", 64'(any_fault), 64'd0);

        // Command change, feedback follows 20 cycles later
        eoutP = 8'b10110011;
        @(negedge clk);
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (c == 20) fbP = 8'b10110011;
            if (monitoring) break;
        end
        chk("settle_after_change_cycles", 64'(c), 64'(SETTLE));
        chk("no_fault_after_change", 64'(any_fault), 64'd0);

        // 7-cycle mismatch is filtered out, 8 cycles latch the fault
        repeat (5) @(negedge clk);
        fb[5] = 1'b1;
        repeat (7) @(negedge clk);
        fb[5] = 1'b0;
        repeat (15) @(negedge clk);
        chk("short_glitch_no_fault", 64'(any_fault), 64'd0);
        fb[5] = 1'b1;
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (fault[5]) break;
        end
        chk("fault_latency_cycles", 64'(c), 64'(2 + FILT));
        chk("fault5_any_fault", 64'(any_fault), 64'd1);

        // Clear ignored while mismatch persists, accepted once it is gone
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr_ignored_fault5", 64'(fault[5]), 64'd1);
        fb[5] = 1'b0;
        repeat (3) @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        chk("clr_accepted_faults", 64'({faultP, fault}), 64'd0);
        chk("clr_accepted_settle", 64'(monitoring), 64'd0);
        count_until_mon(c);
        chk("settle_after_clr_cycles", 64'(c), 64'(SETTLE));

        // Fault gating with all signal outputs commanded on
        eout = 28'hFFFFFFF; fb = 28'hFFFFFFF;
        repeat (SETTLE + 5) @(negedge clk);
        fb[5] = 1'b0;
        repeat (2 + FILT + 2) @(negedge clk);
        chk("gated_fault5", 64'(fault[5]), 64'd1);
        exp_g = 28'hFFFFFFF;
`ifdef FB_FORCE_OFF_EN
        exp_g[5] = 1'b0;
`endif
        chk("gout_with_fault5", 64'(gout), 64'(exp_g));

        // One-cycle reset while faulted
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_fault_faults", 64'({faultP, fault}), 64'd0);
        chk("rst_in_fault_monitoring", 64'(monitoring), 64'd0);
        chk("rst_in_fault_gout", 64'({goutP, gout}), 64'd0);
        eout = '0; fb = '0; eoutP = '0; fbP = '0;
        repeat (SETTLE + 5) @(negedge clk);

        // Randomized command changes, feedback glitches/stuck bits and clears
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            clr_fault = ($urandom_range(0, 29) == 0);
            r   = int'($urandom_range(0, 199));
            idx = int'($urandom_range(0, 35));
            if (r < 2) begin
                v = {eoutP, eout};
                v[idx] = ~v[idx];
                {eoutP, eout} = v;
                {fbP, fb} = v;
            end else if (r < 3) begin
                v = {eoutP, eout};
                v[idx] = ~v[idx];
                {eoutP, eout} = v;
            end else if (r < 6) begin
                v = {fbP, fb};
                v[idx] = ~v[idx];
                {fbP, fb} = v;
            end else if (r < 13) begin
                {fbP, fb} = {eoutP, eout};
            end
        end
        clr_fault = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
